alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream/downstream control stage for the 8-bit combinational ALU (x+y, x&y, x==0 outputs).
//  Holds a small register file and accepts one operation per valid/ready handshake.
//  Fetches two operands onto the ALU inputs, selects the ALU output named by the opcode and writes it back.
//  Reports each completion with a one-cycle done pulse carrying the result and a zero flag.
// PARAMETERS
//  DATA_WIDTH  8  operand/result width; must equal the ALU width (fixed at 8)
//  REG_COUNT   4  number of general registers
//  ADDR_WIDTH  2  register address width; REG_COUNT = 2**ADDR_WIDTH
// PORTS
//  clock          in   1   single clock; all state updates on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  input_valid    in   1   request valid
//  output_ready   out  1   sequencer can accept a request; = (state==IDLE)
//  input_op       in   2   00 ADD, 01 AND, 10 CMP (dst = (a==0)?1:0), 11 LDI (dst = imm)
//  input_dst      in   AW  destination register
//  input_src_a    in   AW  operand A register (drives ALU x)
//  input_src_b    in   AW  operand B register (drives ALU y)
//  input_imm      in   8   immediate, used by LDI only
//  output_alu_x   out  8   registered operand to ALU input_x
//  output_alu_y   out  8   registered operand to ALU input_y
//  input_alu_sum  in   8   from ALU output_sum
//  input_alu_and  in   8   from ALU output_and
//  input_alu_cmp  in   8   from ALU output_cmp
//  output_done    out  1   one-cycle pulse: operation written back
//  output_result  out  8   value written by the last completed op; held until the next done
//  output_zero    out  1   output_result == 0; updated with output_done
//  input_rd_addr  in   AW  debug read address
//  output_rd_data out  8   combinational read of register[input_rd_addr]
// BEHAVIOUR
//  Reset (async, reset_n=0): all registers 0, alu_x/alu_y 0, result 0, zero 0, done 0, state IDLE.
//   Reset mid-operation aborts it: no write-back, no done pulse.
//  FSM: IDLE -> FETCH -> EXEC -> WB -> IDLE, one cycle per state except IDLE.
//   IDLE:  ready=1; input_valid=1 at edge E0 latches op/dst/src_a/src_b/imm and enters FETCH.
//   FETCH: at E1, alu_x <= reg[src_a], alu_y <= reg[src_b]; enters EXEC.
//   EXEC:  ALU settles combinationally; at E2 result_q <= sum|and|cmp per op (LDI: imm); enters WB.
//   WB:    at E3, reg[dst] <= result_q, output_result <= result_q, output_zero <= (result_q==0),
//          output_done <= 1; enters IDLE.
//  output_done is high exactly for the cycle after E3, then cleared at the next edge.
//  Latency: accept edge E0 -> done visible after E3 (3 edges). Throughput: one op per 4 cycles;
//   ready is high in the done cycle, so the next request can be accepted at E4.
//  input_valid while not IDLE: ignored; request inputs are not sampled and no error is raised.
//  Request fields are sampled only at the accept edge; later changes have no effect.
//  ADD wraps modulo 256 (no carry retained). CMP ignores operand B. LDI uses the same latency;
//   alu_x/alu_y are still loaded from src_a/src_b but the ALU outputs are ignored.
//  dst may equal src_a/src_b: operands are read in FETCH, before the WB write, so old values are used.
//  Write-back of op N completes before op N+1's FETCH, so no forwarding is needed.
//  output_rd_data reflects a WB write from the edge after E3 onward.
// TESTING
//  1 Reset: hold reset_n=0 mid-operation (in EXEC) -> all outputs 0, state IDLE, no done, regs 0.
//  2 LDI r1=0x7F, LDI r2=0x81, ADD r3=r1+r2 -> done 3 edges after accept, result 0x00, zero=1, r3=0x00.
//  3 LDI r0=0xF0, r1=0x3C; AND r2=r0&r1 -> result 0x30, zero=0; rd_addr=2 reads 0x30.
//  4 CMP r3=(r0==0) with r0=0 -> result 0x01; with r0=0x05 -> result 0x00, zero=1.
//  5 valid held high throughout: back-to-back ADD r1=r1+r1 from r1=1 -> done every 4 cycles, r1=2,4,8;
//    a differing request presented while busy is never executed.
//  6 Self-overwrite: r2=0x10, ADD r2=r2+r2 -> result 0x20; second identical op -> 0x40.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Four-phase control stage for an 8-bit combinational ALU with
//                a small register file and a valid/ready request interface.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  input_valid,
    output logic                  output_ready,
    input  logic [1:0]            input_op,
    input  logic [ADDR_WIDTH-1:0] input_dst,
    input  logic [ADDR_WIDTH-1:0] input_src_a,
    input  logic [ADDR_WIDTH-1:0] input_src_b,
    input  logic [DATA_WIDTH-1:0] input_imm,
    output logic [DATA_WIDTH-1:0] output_alu_x,
    output logic [DATA_WIDTH-1:0] output_alu_y,
    input  logic [DATA_WIDTH-1:0] input_alu_sum,
    input  logic [DATA_WIDTH-1:0] input_alu_and,
    input  logic [DATA_WIDTH-1:0] input_alu_cmp,
    output logic                  output_done,
    output logic [DATA_WIDTH-1:0] output_result,
    output logic                  output_zero,
    input  logic [ADDR_WIDTH-1:0] input_rd_addr,
    output logic [DATA_WIDTH-1:0] output_rd_data
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_AND = 2'b01;
    localparam logic [1:0] c_OP_CMP = 2'b10;
    localparam logic [1:0] c_OP_LDI = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_accept;

    logic [1:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_dst;
    logic [ADDR_WIDTH-1:0]   r_src_a;
    logic [ADDR_WIDTH-1:0]   r_src_b;
    logic [DATA_WIDTH-1:0]   r_imm;
    logic [DATA_WIDTH-1:0]   r_alu_x;
    logic [DATA_WIDTH-1:0]   r_alu_y;
    logic [DATA_WIDTH-1:0]   r_result_q;
    logic [DATA_WIDTH-1:0]   w_exec_result;
    logic [DATA_WIDTH-1:0]   r_out_result;
    logic                    r_out_zero;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_regs [REG_COUNT];

    assign output_ready   = (r_state == S_IDLE);
    assign w_accept       = input_valid && output_ready;
    assign output_alu_x   = r_alu_x;
    assign output_alu_y   = r_alu_y;
    assign output_done    = r_done;
    assign output_result  = r_out_result;
    assign output_zero    = r_out_zero;
    assign output_rd_data = r_regs[input_rd_addr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // LDI bypasses the ALU; the operand registers are still loaded for it.
    always_comb begin
        w_exec_result = input_alu_sum;
        case (r_op)
            c_OP_ADD: w_exec_result = input_alu_sum;
            c_OP_AND: w_exec_result = input_alu_and;
            c_OP_CMP: w_exec_result = input_alu_cmp;
            c_OP_LDI: w_exec_result = r_imm;
            default:  w_exec_result = input_alu_sum;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op         <= '0;
            r_dst        <= '0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_imm        <= '0;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_result_q   <= '0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == S_WB);
            if (w_accept) begin
                r_op    <= input_op;
                r_dst   <= input_dst;
                r_src_a <= input_src_a;
                r_src_b <= input_src_b;
                r_imm   <= input_imm;
            end
            if (r_state == S_FETCH) begin
                r_alu_x <= r_regs[r_src_a];
                r_alu_y <= r_regs[r_src_b];
            end
            if (r_state == S_EXEC) begin
                r_result_q <= w_exec_result;
            end
            if (r_state == S_WB) begin
                r_out_result <= r_result_q;
                r_out_zero   <= (r_result_q == '0);
            end
        end
    end

    // Operands are read in FETCH, so a write-back here never needs forwarding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_WB) begin
            r_regs[r_dst] <= r_result_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                behavioural 8-bit ALU model on the operand outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam logic [1:0] c_ADD = 2'b00;
    localparam logic [1:0] c_AND = 2'b01;
    localparam logic [1:0] c_CMP = 2'b10;
    localparam logic [1:0] c_LDI = 2'b11;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       input_valid;
    logic       output_ready;
    logic [1:0] input_op;
    logic [1:0] input_dst;
    logic [1:0] input_src_a;
    logic [1:0] input_src_b;
    logic [7:0] input_imm;
    logic [7:0] output_alu_x;
    logic [7:0] output_alu_y;
    logic [7:0] w_alu_sum;
    logic [7:0] w_alu_and;
    logic [7:0] w_alu_cmp;
    logic       output_done;
    logic [7:0] output_result;
    logic       output_zero;
    logic [1:0] input_rd_addr;
    logic [7:0] output_rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] m_regs [4];

    always #5 clock = ~clock;

    assign w_alu_sum = output_alu_x + output_alu_y;
    assign w_alu_and = output_alu_x & output_alu_y;
    assign w_alu_cmp = (output_alu_x == 8'h00) ? 8'h01 : 8'h00;

    alu_op_sequencer #(
        .DATA_WIDTH (8),
        .REG_COUNT  (4),
        .ADDR_WIDTH (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .input_valid    (input_valid),
        .output_ready   (output_ready),
        .input_op       (input_op),
        .input_dst      (input_dst),
        .input_src_a    (input_src_a),
        .input_src_b    (input_src_b),
        .input_imm      (input_imm),
        .output_alu_x   (output_alu_x),
        .output_alu_y   (output_alu_y),
        .input_alu_sum  (w_alu_sum),
        .input_alu_and  (w_alu_and),
        .input_alu_cmp  (w_alu_cmp),
        .output_done    (output_done),
        .output_result  (output_result),
        .output_zero    (output_zero),
        .input_rd_addr  (input_rd_addr),
        .output_rd_data (output_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!output_ready && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", {31'd0, output_ready}, 32'd1);
    endtask

    task automatic read_reg(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        input_rd_addr = addr;
        #1;
        check(tag, {24'd0, output_rd_data}, {24'd0, exp});
    endtask

    // Issues one request and checks operand fetch, 3-edge latency, result and write-back.
    task automatic do_op(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                         input logic [1:0] b, input logic [7:0] imm, input logic [7:0] exp_res);
        wait_ready();
        input_valid = 1'b1;
        input_op    = op;
        input_dst   = dst;
        input_src_a = a;
        input_src_b = b;
        input_imm   = imm;
        tick();
        input_valid = 1'b0;
        input_op    = ~op;
        input_dst   = ~dst;
        input_src_a = ~a;
        input_src_b = ~b;
        input_imm   = ~imm;
        check("busy_ready", {31'd0, output_ready}, 32'd0);
        check("done_e0", {31'd0, output_done}, 32'd0);
        tick();
        check("alu_x", {24'd0, output_alu_x}, {24'd0, m_regs[a]});
        check("alu_y", {24'd0, output_alu_y}, {24'd0, m_regs[b]});
        tick();
        check("done_e2", {31'd0, output_done}, 32'd0);
        tick();
        check("done_e3", {31'd0, output_done}, 32'd1);
        check("result", {24'd0, output_result}, {24'd0, exp_res});
        check("zero", {31'd0, output_zero}, {31'd0, (exp_res == 8'h00)});
        check("ready_in_done", {31'd0, output_ready}, 32'd1);
        m_regs[dst] = exp_res;
        read_reg(dst, exp_res, "wb_reg");
        tick();
        check("done_clear", {31'd0, output_done}, 32'd0);
        check("result_hold", {24'd0, output_result}, {24'd0, exp_res});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        input_valid   = 1'b0;
        input_op      = 2'b00;
        input_dst     = 2'd0;
        input_src_a   = 2'd0;
        input_src_b   = 2'd0;
        input_imm     = 8'h00;
        input_rd_addr = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        tick();
        tick();
        check("rst_ready", {31'd0, output_ready}, 32'd1);
        check("rst_done", {31'd0, output_done}, 32'd0);
        check("rst_result", {24'd0, output_result}, 32'd0);
        check("rst_alu_x", {24'd0, output_alu_x}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset in EXEC aborts the op and clears everything, including earlier writes.
        do_op(c_LDI, 2'd1, 2'd0, 2'd0, 8'h55, 8'h55);
        wait_ready();
        input_valid = 1'b1;
        input_op    = c_LDI;
        input_dst   = 2'd2;
        input_imm   = 8'h66;
        tick();
        input_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, output_ready}, 32'd1);
        check("abort_done", {31'd0, output_done}, 32'd0);
        check("abort_result", {24'd0, output_result}, 32'd0);
        check("abort_zero", {31'd0, output_zero}, 32'd0);
        check("abort_alu_y", {24'd0, output_alu_y}, 32'd0);
        read_reg(2'd1, 8'h00, "abort_r1");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        tick();
        tick();
        tick();
        check("abort_no_done", {31'd0, output_done}, 32'd0);
        read_reg(2'd2, 8'h00, "abort_r2");

        // ADD wrap to zero.
        do_op(c_LDI, 2'd1, 2'd0, 2'd0, 8'h7F, 8'h7F);
        do_op(c_LDI, 2'd2, 2'd0, 2'd0, 8'h81, 8'h81);
        do_op(c_ADD, 2'd3, 2'd1, 2'd2, 8'hAA, 8'h00);

        // AND.
        do_op(c_LDI, 2'd0, 2'd3, 2'd3, 8'hF0, 8'hF0);
        do_op(c_LDI, 2'd1, 2'd3, 2'd3, 8'h3C, 8'h3C);
        do_op(c_AND, 2'd2, 2'd0, 2'd1, 8'h00, 8'h30);
        read_reg(2'd2, 8'h30, "and_rd2");

        // CMP ignores operand B.
        do_op(c_LDI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
        do_op(c_CMP, 2'd3, 2'd0, 2'd2, 8'hFF, 8'h01);
        do_op(c_LDI, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05);
        do_op(c_CMP, 2'd3, 2'd0, 2'd2, 8'h00, 8'h00);

        // valid held high: back-to-back ADD r1=r1+r1, busy-time request must be ignored.
        do_op(c_LDI, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01);
        do_op(c_LDI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
        wait_ready();
        input_valid = 1'b1;
        input_op    = c_ADD;
        input_dst   = 2'd1;
        input_src_a = 2'd1;
        input_src_b = 2'd1;
        input_imm   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_busy", {31'd0, output_ready}, 32'd0);
            input_op    = c_LDI;
            input_dst   = 2'd0;
            input_imm   = 8'hEE;
            tick();
            tick();
            check("b2b_no_early_done", {31'd0, output_done}, 32'd0);
            input_op    = c_ADD;
            input_dst   = 2'd1;
            input_imm   = 8'h00;
            tick();
            check("b2b_done", {31'd0, output_done}, 32'd1);
            check("b2b_result", {24'd0, output_result}, {24'd0, 8'h02 << i});
            if (i == 2) input_valid = 1'b0;
        end
        tick();
        check("b2b_done_clear", {31'd0, output_done}, 32'd0);
        check("b2b_idle", {31'd0, output_ready}, 32'd1);
        read_reg(2'd1, 8'h08, "b2b_r1");
        read_reg(2'd0, 8'h00, "b2b_r0_untouched");
        m_regs[1] = 8'h08;

        // dst == src: old values are used.
        do_op(c_LDI, 2'd2, 2'd0, 2'd0, 8'h10, 8'h10);
        do_op(c_ADD, 2'd2, 2'd2, 2'd2, 8'h00, 8'h20);
        do_op(c_ADD, 2'd2, 2'd2, 2'd2, 8'h00, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
